aes_round_sequencer: RTL
========================

AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 Parameter NUM_CH, default 2, range 1..8: number of independent request channels.
REQ-002 Parameter ROUND_LAT, default 1, range 1..4: cycles from issuing a round on the round bus to its result on rnd_data.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  NUM_CH  per-channel request valid.
REQ-006 in_ready  output  NUM_CH  per-channel grant; one-hot or zero.
REQ-007 in_block  input  NUM_CH*128  per-channel input block; channel i occupies bits [128*i+127:128*i].
REQ-008 in_encdec  input  NUM_CH  per-channel mode; 0 = encipher, 1 = decipher.
REQ-009 keylen  input  2  key size: 0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = reserved.
REQ-010 key_ready  input  1  key memory has expanded the current key.
REQ-011 round  output  4  round index sent to key memory and round engine.
REQ-012 rnd_state  output  128  state word issued to the round engine.
REQ-013 rnd_first / rnd_final  output  1 each  flags: initial AddRoundKey only / final round without MixColumns.
REQ-014 rnd_dec  output  1  round engine applies inverse transforms.
REQ-015 rnd_data  input  128  round engine result, valid ROUND_LAT cycles after issue.
REQ-016 out_valid / out_ready  output / input  1 each  result handshake.
REQ-017 out_block  output  128  final result.
REQ-018 out_ch  output  3  channel index of the result.
REQ-019 out_encdec  output  1  mode of the result.
REQ-020 busy  output  1  high in every state other than IDLE.

Function
REQ-021 FSM states and transitions: IDLE -> ISSUE on accept; ISSUE -> WAIT; WAIT -> ISSUE when ROUND_LAT has elapsed and rounds remain; WAIT -> DONE after the last round; DONE -> IDLE on out_valid && out_ready.
REQ-022 Grant conditions: in IDLE only, with key_ready=1 and keylen!=3, round-robin among asserted in_valid; the pointer starts at channel 0 and moves to the channel after the winner.
REQ-023 Accept timing: in_valid[i] && in_ready[i] in cycle T; block, mode, keylen and channel are registered at the end of cycle T.
REQ-024 Round count: Nr = 10 / 12 / 14 for keylen 0 / 1 / 2; Nr+1 rounds are issued in total.
REQ-025 Round index sequence: encipher issues 0..Nr ascending; decipher issues Nr..0 descending.
REQ-026 rnd_first and rnd_final: rnd_first marks the first issue; rnd_final marks the last issue.
REQ-027 Issue timing: round k is issued in cycle T+1+k*ROUND_LAT; rnd_state is the input block for k=0, otherwise the previous rnd_data.
REQ-028 Result timing: the last result is captured at T+1+(Nr+1)*ROUND_LAT; out_valid rises the following cycle.
REQ-029 Result hold: out_block, out_ch and out_encdec stay stable while out_valid=1 && out_ready=0.
REQ-030 Back-to-back: no new grant is made in the cycle that the handshake completes; the next grant is possible one cycle later.
REQ-031 Mid-operation changes: changes to keylen, key_ready or in_* after accept do not affect the operation in flight.
REQ-032 Reserved keylen: keylen=3 in IDLE holds in_ready at 0 and stalls without error.
REQ-033 round, rnd_state and rnd_* are 0 while the FSM is in IDLE or DONE.

Reset
REQ-034 On rst_n low, asynchronously:
- FSM = IDLE; arbiter pointer = 0;
- in_ready, out_valid, busy, rnd_first, rnd_final and rnd_dec = 0;
- round, rnd_state, out_block, out_ch and out_encdec = 0.
REQ-035 Reset mid-operation discards the operation in flight and produces no result.

Configuration
REQ-036 Macro AES_DECIPHER_EN, defined: decipher mode is supported as in REQ-025.
REQ-037 Macro AES_DECIPHER_EN, undefined:
- in_encdec is ignored and every request is enciphered;
- rnd_dec and out_encdec are tied to 0;
- no descending round counter is built.

Verification
REQ-038 Encipher latency, with a reference round engine and key memory, ROUND_LAT=1: AES-128 key 000102..0f, channel 0 block 00112233445566778899aabbccddeeff -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at T+13, rounds 0..10.
REQ-039 Decipher with AES-256 (key 000102..1f): block 8ea2b7ca516745bfeafc49904b496089, in_encdec=1 -> out_block 00112233445566778899aabbccddeeff, rounds 14..0, out_encdec=1.
REQ-040 Arbitration: NUM_CH=3, all in_valid held high -> grants in order 0, 1, 2, 0, 1; out_ch matches each grant.
REQ-041 Backpressure: out_ready low for 5 cycles after out_valid -> result stable, no new grant; handshake completes, next grant 1 cycle later.
REQ-042 Abort: rst_n pulsed low in WAIT at round 5 -> all outputs 0 immediately, no out_valid afterwards; a fresh request completes correctly.
REQ-043 Stalls: keylen=3 or key_ready=0 with in_valid high for 10 cycles -> in_ready stays 0; once released, a grant follows in the next cycle.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: round-robin multi-channel AES round issue/collect FSM.
// Build option AES_DECIPHER_EN adds decipher mode (descending round order).
module aes_round_sequencer #(
  parameter int NUM_CH    = 2,
  parameter int ROUND_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     in_valid,
  output logic [NUM_CH-1:0]     in_ready,
  input  logic [NUM_CH*128-1:0] in_block,
  input  logic [NUM_CH-1:0]     in_encdec,
  input  logic [1:0]            keylen,
  input  logic                  key_ready,
  output logic [3:0]            round,
  output logic [127:0]          rnd_state,
  output logic                  rnd_first,
  output logic                  rnd_final,
  output logic                  rnd_dec,
  input  logic [127:0]          rnd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_block,
  output logic [2:0]            out_ch,
  output logic                  out_encdec,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE
  } st_t;

  st_t          st_q, st_d;
  logic [2:0]   ptr_q, win, ch_q, wcnt_q;
  logic         hit, grant_ok, accept;
  logic         last, issuing;
  logic [127:0] blk_q, blk_sel;
  logic [1:0]   kl_q;
  logic [3:0]   rnd_q, nr, nr_in;
  logic         first_q, dec_q, dec_sel;

  assign nr       = 4'd10 + {1'b0, kl_q, 1'b0};
  assign nr_in    = 4'd10 + {1'b0, keylen, 1'b0};
  assign grant_ok = rst_n && (st_q == S_IDLE) &&
                    key_ready && (keylen != 2'd3);
  assign accept   = grant_ok && hit;
  assign issuing  = (st_q == S_ISSUE);

  // Winner is the valid channel at the smallest distance from ptr.
  always_comb begin
    int off;
    int best;
    best = NUM_CH;
    win  = '0;
    hit  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      off = i - int'(ptr_q);
      if (off < 0) off = off + NUM_CH;
      if (in_valid[i] && off < best) begin
        best = off;
        win  = 3'(i);
        hit  = 1'b1;
      end
    end
    blk_sel  = '0;
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win == 3'(i)) blk_sel = in_block[i*128 +: 128];
      in_ready[i] = accept && (win == 3'(i));
    end
  end

`ifdef AES_DECIPHER_EN
  always_comb begin
    dec_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (win == 3'(i)) dec_sel = in_encdec[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dec_q <= 1'b0;
    else if (accept) dec_q <= dec_sel;
  end

  assign last = dec_q ? (rnd_q == 4'd0) : (rnd_q == nr);
`else
  logic unused_encdec;
  assign unused_encdec = ^in_encdec;
  assign dec_sel       = 1'b0;
  assign dec_q         = 1'b0;
  assign last          = (rnd_q == nr);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= S_IDLE;
    else        st_q <= st_d;
  end

  // With ROUND_LAT=1 the result lands in the next issue slot.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE:  if (accept) st_d = S_ISSUE;
      S_ISSUE: st_d = (!last && ROUND_LAT == 1) ? S_ISSUE : S_WAIT;
      S_WAIT: begin
        if (!last && wcnt_q == 3'(ROUND_LAT - 1))
          st_d = S_ISSUE;
        else if (last && wcnt_q == 3'(ROUND_LAT))
          st_d = S_DONE;
      end
      S_DONE:  if (out_ready) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_comb begin
    round     = '0;
    rnd_state = '0;
    rnd_first = 1'b0;
    rnd_final = 1'b0;
    rnd_dec   = 1'b0;
    if (issuing) begin
      round     = rnd_q;
      rnd_state = first_q ? blk_q : rnd_data;
      rnd_first = first_q;
      rnd_final = last;
      rnd_dec   = dec_q;
    end
  end

  assign busy      = (st_q != S_IDLE);
  assign out_valid = (st_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      blk_q      <= '0;
      kl_q       <= '0;
      ch_q       <= '0;
      rnd_q      <= '0;
      wcnt_q     <= '0;
      first_q    <= 1'b0;
      out_block  <= '0;
      out_ch     <= '0;
      out_encdec <= 1'b0;
    end else begin
      if (accept) begin
        blk_q   <= blk_sel;
        kl_q    <= keylen;
        ch_q    <= win;
        first_q <= 1'b1;
        rnd_q   <= dec_sel ? nr_in : 4'd0;
        ptr_q   <= (win == 3'(NUM_CH - 1)) ? 3'd0 : win + 3'd1;
      end
      if (issuing) begin
        first_q <= 1'b0;
        wcnt_q  <= 3'd1;
      end
      if (st_q == S_WAIT) wcnt_q <= wcnt_q + 3'd1;
      if (st_q != S_IDLE && st_d == S_ISSUE) begin
`ifdef AES_DECIPHER_EN
        rnd_q <= dec_q ? rnd_q - 4'd1 : rnd_q + 4'd1;
`else
        rnd_q <= rnd_q + 4'd1;
`endif
      end
      if (st_q == S_WAIT && st_d == S_DONE) begin
        out_block  <= rnd_data;
        out_ch     <= ch_q;
        out_encdec <= dec_q;
      end
    end
  end

endmodule
